// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
// Optional feature macro used by reg_file_mp: REG_FILE_BYPASS_EN.
package reg_file_pkg;

    // Init/run phase of the file.
    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    // Widest word merge_be can handle; callers zero-extend into it.
    localparam int RF_MAX_W  = 256;
    localparam int RF_MAX_BE = RF_MAX_W / 8;

    // Number of entries addressed by an addr_w-bit address.
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Replace the bytes of old_w selected by be with the matching bytes of wr_w.
    function automatic logic [RF_MAX_W-1:0] merge_be(
        input logic [RF_MAX_W-1:0]  old_w,
        input logic [RF_MAX_W-1:0]  wr_w,
        input logic [RF_MAX_BE-1:0] be
    );
        logic [RF_MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < RF_MAX_BE; b++) begin
            if (be[b]) res[b*8 +: 8] = wr_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Post-reset clear sequencer: walks clr_addr over every entry once, then
// raises ready and stays in RUN until the next reset.
module reg_file_init_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    rf_state_e         state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, cnt_nx;

    // State and counter registers; reset restarts the clear pass from entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= cnt_nx;
        end
    end

    // Next state: advance one entry per cycle, leave INIT after the last
    // entry without letting the counter wrap into a second pass.
    always_comb begin
        state_nx = state;
        cnt_nx   = clr_cnt;
        if (state == RF_INIT) begin
            if (clr_cnt == '1) state_nx = RF_RUN;
            else               cnt_nx   = clr_cnt + 1'b1;
        end
    end

    // No clear happens in a reset cycle, so contents survive until INIT runs.
    assign clr_en   = rst_n && (state == RF_INIT);
    assign clr_addr = clr_cnt;
    assign ready    = (state == RF_RUN);

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with byte-enabled writes,
// optional hardwired-zero entry 0 and a post-reset clear pass gated by ready.
// Optional macro REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding.
// DATA_W must be a multiple of 8 and no wider than RF_MAX_W.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int BE_W    = DATA_W / 8;
    localparam int DEPTH   = rf_depth(ADDR_W);
    localparam bit HW_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;

    // Narrow wrapper around the shared byte merge.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] wr_w,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(merge_be(RF_MAX_W'(old_w), RF_MAX_W'(wr_w), RF_MAX_BE'(be)));
    endfunction

    reg_file_init_ctrl #(.ADDR_W(ADDR_W)) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // User writes only land once the clear pass is done; entry 0 drops
    // writes when hardwired.
    assign wr_fire = ready && wr_en && !(HW_ZERO && (wr_addr == '0));

    // Storage update: clear pass has priority, otherwise byte-merged write.
    always_ff @(posedge clk) begin
        if (clr_en)       mem[clr_addr] <= '0;
        else if (wr_fire) mem[wr_addr]  <= merge(mem[wr_addr], wr_data, wr_be);
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Read mux: stored word, optional forwarding, then zero overrides
        // for INIT and the hardwired entry.
        always_comb begin
            word = mem[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en && (addr == wr_addr)) word = merge(word, wr_data, wr_be);
`else
`endif
            if (!ready || (HW_ZERO && (addr == '0))) word = '0;
        end

        assign rd_data[p*DATA_W +: DATA_W] = word;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance (2 ports, ZERO_REG=1)
// and a wide instance (4 ports, 64-bit, ZERO_REG=0) sharing clock and reset.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst_n;

    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic         a_wr_en;
    logic [4:0]   a_wr_addr;
    logic [3:0]   a_wr_be;
    logic [31:0]  a_wr_data;
    logic         a_ready;

    logic [19:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic         b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [7:0]   b_wr_be;
    logic [63:0]  b_wr_data;
    logic         b_ready;

    int n_cmp = 0;
    int n_err = 0;
    int early;

    always #5 clk = ~clk;

    reg_file_mp u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
        .ready(a_ready)
    );

    reg_file_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
        .ready(b_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one posedge; inputs are driven and outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] a_port(input int p);
        return a_rd_data[p*32 +: 32];
    endfunction

    function automatic logic [63:0] b_port(input int p);
        return b_rd_data[p*64 +: 64];
    endfunction

    initial begin
        rst_n = 1'b0;
        a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_be = '0; a_wr_data = '0;
        b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_be = '0; b_wr_data = '0;

        // Reset for two edges.
        tick(); tick();
        chk("reset_ready_a", 64'(a_ready), 64'd0);
        chk("reset_ready_b", 64'(b_ready), 64'd0);
        rst_n = 1'b1;

        // INIT: ready low for 31 edges; writes to B entry 9 after it was cleared are ignored.
        early = 0;
        a_rd_addr = {5'd1, 5'd5};
        b_rd_addr = {5'd0, 5'd0, 5'd0, 5'd9};
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (a_ready !== 1'b0 || b_ready !== 1'b0) early++;
            if (i == 5) chk("init_read_zero_a", 64'(a_port(0)), 64'd0);
            if (i == 10) begin
                b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_be = 8'hFF;
                b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            if (i == 20) chk("init_read_zero_b", b_port(0), 64'd0);
        end
        b_wr_en = 1'b0;
        chk("ready_early", 64'(early), 64'd0);
        tick();
        chk("ready_edge32_a", 64'(a_ready), 64'd1);
        chk("ready_edge32_b", 64'(b_ready), 64'd1);
        chk("init_write_ignored_b9", b_port(0), 64'd0);

        // Every entry of A reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            a_rd_addr = {5'(31 - i), 5'(i)};
            #1;
            chk("cleared_p0", 64'(a_port(0)), 64'd0);
            chk("cleared_p1", 64'(a_port(1)), 64'd0);
        end

        // Full write then partial byte write.
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_be = 4'hF; a_wr_data = 32'hDEADBEEF;
        tick();
        a_wr_be = 4'h2; a_wr_data = 32'h0000AA00;
        tick();
        a_wr_en = 1'b0;
        a_rd_addr = {5'd5, 5'd5};
        #1;
        chk("byte_merge_p0", 64'(a_port(0)), 64'hDEADAAEF);
        chk("byte_merge_p1", 64'(a_port(1)), 64'hDEADAAEF);
        a_wr_en = 1'b1; a_wr_be = 4'h0; a_wr_data = 32'h0;
        tick();
        a_wr_en = 1'b0;
        chk("be_zero_noop", 64'(a_port(0)), 64'hDEADAAEF);

        // Entry 0: hardwired on A, ordinary on B.
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_be = 4'hF; a_wr_data = 32'hFFFFFFFF;
        a_rd_addr = '0;
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_be = 8'hFF; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        b_rd_addr = '0;
        #1;
        chk("zero_reg_same_cycle", 64'(a_port(1)), 64'd0);
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        chk("zero_reg_p0", 64'(a_port(0)), 64'd0);
        chk("zero_reg_p1", 64'(a_port(1)), 64'd0);
        chk("nozero_reg_b", b_port(3), 64'hFFFF_FFFF_FFFF_FFFF);

        // Same-cycle read of the write target.
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_be = 4'hF; a_wr_data = 32'h12345678;
        a_rd_addr = {5'd7, 5'd7};
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("same_cycle_p0", 64'(a_port(0)), 64'h12345678);
        chk("same_cycle_p1", 64'(a_port(1)), 64'h12345678);
`else
        chk("same_cycle_p0", 64'(a_port(0)), 64'h0);
        chk("same_cycle_p1", 64'(a_port(1)), 64'h0);
`endif
        tick();
        a_wr_en = 1'b0;
        chk("next_cycle_p0", 64'(a_port(0)), 64'h12345678);
        chk("next_cycle_p1", 64'(a_port(1)), 64'h12345678);

        // B: independent ports with distinct data, including a partial write.
        b_wr_en = 1'b1; b_wr_be = 8'hFF;
        b_wr_addr = 5'd1; b_wr_data = 64'h1111_2222_3333_4444; tick();
        b_wr_addr = 5'd2; b_wr_data = 64'h5555_6666_7777_8888; tick();
        b_wr_addr = 5'd4; b_wr_data = 64'h0123_4567_89AB_CDEF; tick();
        b_wr_addr = 5'd4; b_wr_be = 8'h81; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        b_wr_en = 1'b0;
        b_rd_addr = {5'd9, 5'd4, 5'd2, 5'd1};
        #1;
        chk("b_port0", b_port(0), 64'h1111_2222_3333_4444);
        chk("b_port1", b_port(1), 64'h5555_6666_7777_8888);
        chk("b_port2", b_port(2), 64'hFF23_4567_89AB_CDFF);
        chk("b_port3_addr9", b_port(3), 64'd0);

        // Reset mid-INIT: preload entry 3, reset, abort INIT at cycle 10, reset again.
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_be = 4'hF; a_wr_data = 32'hCAFEF00D;
        tick();
        a_wr_en = 1'b0;
        a_rd_addr = {5'd5, 5'd3};
        #1;
        chk("preload_3", 64'(a_port(0)), 64'hCAFEF00D);
        rst_n = 1'b0;
        tick();
        chk("rerun_ready_low", 64'(a_ready), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        early = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (a_ready !== 1'b0) early++;
        end
        chk("rerun_ready_early", 64'(early), 64'd0);
        tick();
        chk("rerun_ready_edge32", 64'(a_ready), 64'd1);
        chk("rerun_entry3", 64'(a_port(0)), 64'd0);
        chk("rerun_entry5", 64'(a_port(1)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
